prog_loader: RTL
================

# prog_loader

Boot-time instruction loader that sits directly upstream of the processor's instruction memory and program counter. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive addresses. While loading it holds the processor in reset, then releases it so fetch begins at the loaded program. It replaces hand-driven memory-write sequencing with a synthesizable, restartable sequence.

## Interface
Parameters:
- START_ADDR, 32, instruction-memory address of the first loaded word
- ADDR_STRIDE, 2, address increment per instruction (memory is 16-bit addressed; one instruction = 2 locations)
- MAX_WORDS, 256, maximum instructions per load; must be ≥1
- RESET_CYCLES, 2, cycles the processor reset stays high after the last write; must be ≥1

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- start  in  1  one-cycle pulse; begins a load from IDLE, RUN or ERROR
- s_valid  in  1  instruction word available
- s_data  in  32  instruction word
- s_last  in  1  marks final word of program; sampled with s_valid
- s_ready  out  1  loader accepts a word this cycle
- Write_Address  out  32  instruction-memory write address
- OP_Code  out  32  instruction-memory write data
- Write_Enable  out  1  instruction-memory write strobe, one cycle per word
- cpu_reset  out  1  active-high reset to program counter and pipeline
- done  out  1  program loaded and processor running
- error  out  1  sticky overflow flag; cleared by start or reset
- word_count  out  16  words written in current/last load

## Operation
- States: IDLE, LOAD, FLUSH, RUN, ERROR.
- IDLE: s_ready=0, cpu_reset=1. start → LOAD; address pointer ← START_ADDR, word_count ← 0, error ← 0.
- LOAD: s_ready=1, cpu_reset=1. Beat = s_valid && s_ready. On a beat with word_count < MAX_WORDS: register Write_Address ← pointer, OP_Code ← s_data, Write_Enable ← 1 for the next cycle; pointer += ADDR_STRIDE; word_count += 1. No beat → Write_Enable ← 0, all else held.
- s_last on an accepted, written beat → FLUSH; flush counter ← RESET_CYCLES.
- Overflow: a beat arriving when word_count == MAX_WORDS is consumed but not written (Write_Enable stays 0); error ← 1; → ERROR. This applies whether or not s_last is set.
- FLUSH: s_ready=0, cpu_reset=1; counter decrements each cycle; at 1 → RUN.
- RUN: cpu_reset=0, done=1, s_ready=0. start → LOAD (same initialisation as from IDLE); cpu_reset reasserts and done clears the cycle after start.
- ERROR: cpu_reset=1, done=0, s_ready=0, error=1; only start (→ LOAD) or reset exits.
- start in LOAD or FLUSH is ignored.
- Pointer arithmetic is 32-bit modulo 2^32; wrap is not flagged.
- Write_Address and OP_Code hold their last written values when Write_Enable=0.

## Timing
- Reset (reset low, asynchronous): state=IDLE; s_ready=0, Write_Address=0, OP_Code=0, Write_Enable=0, cpu_reset=1, done=0, error=0, word_count=0.
- Reset deasserted mid-load: the load is abandoned; restart requires start.
- start sampled at edge N → s_ready=1 from N+1.
- Accepted beat at edge N → Write_Enable/Write_Address/OP_Code valid during cycle N→N+1. Back-to-back beats give a continuous Write_Enable, one address per cycle.
- Last beat at edge N → Write_Enable high in cycle N+1 (FLUSH). cpu_reset falls and done rises after RESET_CYCLES edges, i.e. at edge N+RESET_CYCLES.
- Overflow beat at edge N → error=1 and ERROR state from N+1.
- word_count updates on the same edge as the write registers.

## Test plan
- Reset values: hold reset low, toggle clk → all outputs at reset values, cpu_reset=1; release reset → state unchanged until start.
- Basic load, defaults: start, then 3 back-to-back beats 0x28000000, 0xA8000000, 0x6800000F (last on third) → writes to addresses 32, 34, 36 with matching data on consecutive cycles; word_count=3; cpu_reset falls 2 cycles after the last beat edge; done=1.
- Gapped stream: same 3 words with s_valid low 2 cycles between beats → Write_Enable pulses exactly 3 times, addresses 32/34/36, no duplicate writes.
- Overflow, MAX_WORDS=2: 3 beats, last on third → 2 writes (32, 34); third beat consumed but not written; error=1, cpu_reset stays 1, done=0; next start clears error.
- Restart from RUN: after a completed load, pulse start and load 1 word 0x40000000 (last) → cpu_reset rises the cycle after start; write to address 32; word_count=1; done after 2 cycles.
- Async reset mid-load: assert reset low between beat 1 and beat 2 (not on an edge) → outputs go to reset values immediately; after release, s_valid beats are not accepted (s_ready=0) until start.

Source files
------------

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: boot-time instruction loader. Streams 32-bit instruction words
// from a valid/ready source into instruction memory at consecutive addresses,
// holds the processor in reset while loading, then releases it after a short
// flush period so fetch begins at the freshly loaded program.
module prog_loader #(
   parameter int START_ADDR   = 32,
   parameter int ADDR_STRIDE  = 2,
   parameter int MAX_WORDS    = 256,
   parameter int RESET_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic [31:0] Write_Address,
   output logic [31:0] OP_Code,
   output logic        Write_Enable,
   output logic        cpu_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count
);

   // The flush counter only needs to hold RESET_CYCLES; keep it at least one bit wide.
   localparam int FLUSH_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

   localparam logic [31:0]        START_VALUE  = 32'(START_ADDR);
   localparam logic [31:0]        STRIDE_VALUE = 32'(ADDR_STRIDE);
   localparam logic [15:0]        MAX_COUNT    = 16'(MAX_WORDS);
   localparam logic [FLUSH_W-1:0] FLUSH_LOAD   = FLUSH_W'(RESET_CYCLES);
   localparam logic [FLUSH_W-1:0] FLUSH_ONE    = FLUSH_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      RUN,
      ERROR
   } state_t;

   state_t              state;
   logic [31:0]         addr_ptr;
   logic [FLUSH_W-1:0]  flush_cnt;
   logic                beat;
   logic                room;

   // A beat is a word handed over by the source; s_ready is only ever high in LOAD.
   assign beat = s_valid && s_ready;

   // There is still space for another word in the current load.
   assign room = (word_count < MAX_COUNT);

   // Loader sequencer: state, memory-write registers and all handshake/status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         addr_ptr      <= '0;
         flush_cnt     <= '0;
         s_ready       <= 1'b0;
         Write_Address <= '0;
         OP_Code       <= '0;
         Write_Enable  <= 1'b0;
         cpu_reset     <= 1'b1;
         done          <= 1'b0;
         error         <= 1'b0;
         word_count    <= '0;
      end else begin
         // The write strobe is a single-cycle pulse per accepted word.
         Write_Enable <= 1'b0;

         case (state)
            // A new load may begin from any resting state; the processor is put
            // back into reset and the previous load's status is forgotten.
            IDLE, RUN, ERROR: begin
               if (start) begin
                  state      <= LOAD;
                  addr_ptr   <= START_VALUE;
                  word_count <= '0;
                  error      <= 1'b0;
                  s_ready    <= 1'b1;
                  cpu_reset  <= 1'b1;
                  done       <= 1'b0;
               end
            end

            LOAD: begin
               if (beat) begin
                  if (room) begin
                     Write_Address <= addr_ptr;
                     OP_Code       <= s_data;
                     Write_Enable  <= 1'b1;
                     addr_ptr      <= addr_ptr + STRIDE_VALUE;
                     word_count    <= word_count + 16'd1;
                     if (s_last) begin
                        state     <= FLUSH;
                        s_ready   <= 1'b0;
                        flush_cnt <= FLUSH_LOAD;
                     end
                  end else begin
                     // Too many words: swallow this one without writing it and
                     // park in ERROR with the processor still held in reset.
                     state   <= ERROR;
                     error   <= 1'b1;
                     s_ready <= 1'b0;
                  end
               end
            end

            FLUSH: begin
               if (flush_cnt == FLUSH_ONE) begin
                  state     <= RUN;
                  cpu_reset <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - FLUSH_ONE;
               end
            end

            default: begin
               state     <= IDLE;
               s_ready   <= 1'b0;
               cpu_reset <= 1'b1;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule
